// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline.
// Registered FSM arbitrating load-use, branch redirect and dmem wait.
module pipeline_stall_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_use_hazard,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             idex_write_en,
    output logic             idex_bubble,
    output logic             exmem_write_en,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BUBBLE   = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [2:0]  LP_FL_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [15:0] LP_WT      = 16'(WAIT_TIMEOUT);
    localparam logic [15:0] LP_WT_M1   = 16'(WAIT_TIMEOUT - 1);

    state_t           r_state;
    logic [2:0]       r_flush_left;
    logic             r_pending;
    logic [15:0]      r_wait_cnt;
    logic [CNT_W-1:0] r_stall_count;
    logic             r_mem_timeout;

    state_t           w_state_nx;
    logic [2:0]       w_flush_left_nx;
    logic             w_pending_nx;
    logic [15:0]      w_wait_cnt_nx;
    logic             w_timeout_hit;

    assign w_timeout_hit = (r_state == MEM_WAIT) && dmem_busy
                           && (r_wait_cnt >= LP_WT_M1);

    // State and debug registers; reset dominates everything
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_flush_left  <= '0;
            r_pending     <= 1'b0;
            r_wait_cnt    <= '0;
            r_stall_count <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_flush_left <= w_flush_left_nx;
            r_pending    <= w_pending_nx;
            r_wait_cnt   <= w_wait_cnt_nx;
            if (r_state != RUN && r_stall_count != {CNT_W{1'b1}})
                r_stall_count <= r_stall_count + 1'b1;
            if (w_timeout_hit)
                r_mem_timeout <= 1'b1;
        end
    end

    // Next-state: dmem_busy > branch_taken > load_use_hazard
    always_comb begin
        w_state_nx      = r_state;
        w_flush_left_nx = r_flush_left;
        w_pending_nx    = r_pending;
        w_wait_cnt_nx   = '0;
        unique case (r_state)
            RUN, BUBBLE: begin
                if (dmem_busy) begin
                    w_state_nx = MEM_WAIT;
                    if (branch_taken) begin
                        w_pending_nx    = 1'b1;
                        w_flush_left_nx = LP_FL_INIT;
                    end
                end else if (branch_taken) begin
                    w_state_nx      = FLUSH;
                    w_flush_left_nx = LP_FL_INIT;
                end else if (load_use_hazard && r_state == RUN) begin
                    w_state_nx = BUBBLE;
                end else begin
                    w_state_nx = RUN;
                end
            end
            MEM_WAIT: begin
                if (dmem_busy) begin
                    w_wait_cnt_nx = (r_wait_cnt < LP_WT)
                                    ? r_wait_cnt + 16'd1 : r_wait_cnt;
                    // A saved (interrupted) flush keeps its remaining count
                    if (branch_taken && !r_pending) begin
                        w_pending_nx    = 1'b1;
                        w_flush_left_nx = LP_FL_INIT;
                    end
                end else if (r_pending) begin
                    w_state_nx   = FLUSH;
                    w_pending_nx = 1'b0;
                end else if (branch_taken) begin
                    w_state_nx      = FLUSH;
                    w_flush_left_nx = LP_FL_INIT;
                end else begin
                    w_state_nx = RUN;
                end
            end
            FLUSH: begin
                if (dmem_busy) begin
                    w_state_nx   = MEM_WAIT;
                    w_pending_nx = 1'b1;
                end else if (r_flush_left == 3'd0) begin
                    w_state_nx = RUN;
                end else begin
                    w_flush_left_nx = r_flush_left - 3'd1;
                end
            end
        endcase
    end

    // Pipeline-register controls decoded from registered state only
    always_comb begin
        pc_write_en    = 1'b1;
        ifid_write_en  = 1'b1;
        ifid_flush     = 1'b0;
        idex_write_en  = 1'b1;
        idex_bubble    = 1'b0;
        exmem_write_en = 1'b1;
        unique case (r_state)
            RUN: begin
            end
            BUBBLE: begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                idex_bubble   = 1'b1;
            end
            MEM_WAIT: begin
                pc_write_en    = 1'b0;
                ifid_write_en  = 1'b0;
                idex_write_en  = 1'b0;
                exmem_write_en = 1'b0;
            end
            FLUSH: begin
                ifid_write_en = 1'b0;
                ifid_flush    = 1'b1;
                idex_bubble   = 1'b1;
            end
        endcase
    end

    assign state_o     = r_state;
    assign stall_count = r_stall_count;
    assign mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller.
// Main instance FLUSH_CYCLES=2/WAIT_TIMEOUT=8; side instance FLUSH_CYCLES=1/CNT_W=3.
module tb_pipeline_stall_controller;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic lu = 1'b0;
    logic br = 1'b0;
    logic busy = 1'b0;

    logic        pc_we, ifid_we, ifid_fl, idex_we, idex_bb, exmem_we;
    logic [1:0]  st;
    logic [15:0] scnt;
    logic        tmo;

    logic        pc_we1, ifid_we1, ifid_fl1, idex_we1, idex_bb1, exmem_we1;
    logic [1:0]  st1;
    logic [2:0]  scnt1;
    logic        tmo1;

    logic [5:0] ctl, ctl1;
    assign ctl  = {pc_we, ifid_we, ifid_fl, idex_we, idex_bb, exmem_we};
    assign ctl1 = {pc_we1, ifid_we1, ifid_fl1, idex_we1, idex_bb1, exmem_we1};

    localparam logic [5:0] C_RUN   = 6'b110101;
    localparam logic [5:0] C_BUB   = 6'b000111;
    localparam logic [5:0] C_WAIT  = 6'b000000;
    localparam logic [5:0] C_FLUSH = 6'b101111;

    int total = 0;
    int bad = 0;

    pipeline_stall_controller #(
        .FLUSH_CYCLES(2), .WAIT_TIMEOUT(8), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset),
        .load_use_hazard(lu), .branch_taken(br), .dmem_busy(busy),
        .pc_write_en(pc_we), .ifid_write_en(ifid_we), .ifid_flush(ifid_fl),
        .idex_write_en(idex_we), .idex_bubble(idex_bb),
        .exmem_write_en(exmem_we), .state_o(st),
        .stall_count(scnt), .mem_timeout(tmo)
    );

    pipeline_stall_controller #(
        .FLUSH_CYCLES(1), .WAIT_TIMEOUT(255), .CNT_W(3)
    ) dut1 (
        .clk(clk), .reset(reset),
        .load_use_hazard(lu), .branch_taken(br), .dmem_busy(busy),
        .pc_write_en(pc_we1), .ifid_write_en(ifid_we1), .ifid_flush(ifid_fl1),
        .idex_write_en(idex_we1), .idex_bubble(idex_bb1),
        .exmem_write_en(exmem_we1), .state_o(st1),
        .stall_count(scnt1), .mem_timeout(tmo1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; lu = 1'b0; br = 1'b0; busy = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (ctl !== C_RUN) begin
            bad++; $display("FAIL rst_ctl got=%b exp=%b", ctl, C_RUN);
        end
        total++;
        if (tmo !== 1'b0) begin
            bad++; $display("FAIL rst_tmo got=%b exp=0", tmo);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (st !== 2'd0 || ctl !== C_RUN || scnt !== 16'd0) begin
                bad++;
                $display("FAIL idle%0d st=%0d ctl=%b cnt=%0d exp st=0 ctl=%b cnt=0",
                         i, st, ctl, scnt, C_RUN);
            end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        lu = 1'b1;
        tick();
        lu = 1'b0;
        total++;
        if (st !== 2'd1 || ctl !== C_BUB) begin
            bad++; $display("FAIL lu_bubble st=%0d ctl=%b exp st=1 ctl=%b", st, ctl, C_BUB);
        end
        tick();
        total++;
        if (st !== 2'd0 || scnt !== 16'd1) begin
            bad++; $display("FAIL lu_ret st=%0d cnt=%0d exp st=0 cnt=1", st, scnt);
        end
        // held hazard: one bubble only, then back to RUN
        lu = 1'b1;
        tick();
        tick();
        lu = 1'b0;
        total++;
        if (st !== 2'd0 || scnt !== 16'd2) begin
            bad++; $display("FAIL lu_held st=%0d cnt=%0d exp st=0 cnt=2", st, scnt);
        end
    endtask

    task automatic test_branch();
        do_reset();
        br = 1'b1;
        tick();
        total++;
        if (st !== 2'd3 || ctl !== C_FLUSH) begin
            bad++; $display("FAIL br_fl1 st=%0d ctl=%b exp st=3 ctl=%b", st, ctl, C_FLUSH);
        end
        total++;
        if (st1 !== 2'd3 || ctl1 !== C_FLUSH) begin
            bad++; $display("FAIL br1_fl1 st=%0d ctl=%b exp st=3 ctl=%b", st1, ctl1, C_FLUSH);
        end
        tick();
        br = 1'b0;
        total++;
        if (st !== 2'd3 || ctl !== C_FLUSH) begin
            bad++; $display("FAIL br_fl2 st=%0d ctl=%b exp st=3", st, ctl);
        end
        total++;
        if (st1 !== 2'd0 || scnt1 !== 3'd1) begin
            bad++; $display("FAIL br1_done st=%0d cnt=%0d exp st=0 cnt=1", st1, scnt1);
        end
        tick();
        total++;
        if (st !== 2'd0 || ctl !== C_RUN || scnt !== 16'd2) begin
            bad++; $display("FAIL br_done st=%0d ctl=%b cnt=%0d exp st=0 cnt=2", st, ctl, scnt);
        end
        tick();
        total++;
        if (st !== 2'd0 || scnt !== 16'd2) begin
            bad++; $display("FAIL br_extra st=%0d cnt=%0d exp st=0 cnt=2", st, scnt);
        end
    endtask

    task automatic test_mem_wait();
        int frz;
        do_reset();
        frz = 0;
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            br = (i == 1);
            tick();
            if (st == 2'd2 && ctl == C_WAIT) frz++;
        end
        br = 1'b0;
        busy = 1'b0;
        total++;
        if (frz !== 4) begin
            bad++; $display("FAIL mw_freeze got=%0d exp=4", frz);
        end
        tick();
        total++;
        if (st !== 2'd3 || ctl !== C_FLUSH) begin
            bad++; $display("FAIL mw_fl1 st=%0d ctl=%b exp st=3", st, ctl);
        end
        tick();
        total++;
        if (st !== 2'd3) begin
            bad++; $display("FAIL mw_fl2 st=%0d exp=3", st);
        end
        tick();
        total++;
        if (st !== 2'd0 || scnt !== 16'd6 || tmo !== 1'b0) begin
            bad++; $display("FAIL mw_done st=%0d cnt=%0d tmo=%b exp 0/6/0", st, scnt, tmo);
        end
    endtask

    task automatic test_all_three();
        do_reset();
        busy = 1'b1; br = 1'b1; lu = 1'b1;
        tick();
        busy = 1'b0; br = 1'b0; lu = 1'b0;
        total++;
        if (st !== 2'd2) begin
            bad++; $display("FAIL all3_wait st=%0d exp=2", st);
        end
        tick();
        total++;
        if (st !== 2'd3) begin
            bad++; $display("FAIL all3_flush st=%0d exp=3", st);
        end
    endtask

    task automatic test_flush_interrupt();
        do_reset();
        br = 1'b1;
        tick();
        br = 1'b0;
        busy = 1'b1;
        tick();
        busy = 1'b0;
        total++;
        if (st !== 2'd2) begin
            bad++; $display("FAIL fi_wait st=%0d exp=2", st);
        end
        tick();
        tick();
        total++;
        if (st !== 2'd3) begin
            bad++; $display("FAIL fi_resume st=%0d exp=3", st);
        end
        tick();
        total++;
        if (st !== 2'd0 || scnt !== 16'd4) begin
            bad++; $display("FAIL fi_done st=%0d cnt=%0d exp st=0 cnt=4", st, scnt);
        end
    endtask

    task automatic test_timeout();
        logic exp;
        do_reset();
        busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp = (i >= 8);
            total++;
            if (tmo !== exp) begin
                bad++; $display("FAIL tmo_cyc%0d got=%b exp=%b", i, tmo, exp);
            end
        end
        busy = 1'b0;
        tick();
        total++;
        if (st !== 2'd0 || tmo !== 1'b1 || scnt !== 16'd10) begin
            bad++; $display("FAIL tmo_sticky st=%0d tmo=%b cnt=%0d exp 0/1/10", st, tmo, scnt);
        end
        total++;
        if (scnt1 !== 3'd7 || tmo1 !== 1'b0) begin
            bad++; $display("FAIL sat_cnt cnt=%0d tmo=%b exp cnt=7 tmo=0", scnt1, tmo1);
        end
        tick();
        total++;
        if (tmo !== 1'b1) begin
            bad++; $display("FAIL tmo_hold got=%b exp=1", tmo);
        end
    endtask

    task automatic test_reset_mid_flush();
        br = 1'b1;
        tick();
        br = 1'b0;
        total++;
        if (st !== 2'd3 || tmo !== 1'b1) begin
            bad++; $display("FAIL rmf_pre st=%0d tmo=%b exp st=3 tmo=1", st, tmo);
        end
        reset = 1'b1; lu = 1'b1;
        tick();
        reset = 1'b0; lu = 1'b0;
        total++;
        if (st !== 2'd0 || ctl !== C_RUN || scnt !== 16'd0 || tmo !== 1'b0) begin
            bad++;
            $display("FAIL rmf_post st=%0d ctl=%b cnt=%0d tmo=%b exp 0/%b/0/0",
                     st, ctl, scnt, tmo, C_RUN);
        end
        tick();
        total++;
        if (st !== 2'd0 || scnt !== 16'd0) begin
            bad++; $display("FAIL rmf_next st=%0d cnt=%0d exp 0/0", st, scnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_all_three();
        test_flush_interrupt();
        test_timeout();
        test_reset_mid_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
